// File: rtl/dht_multi_decoder.sv
// Multi-channel DHT11/DHT22 frame decoder.
// Verifies the 8-bit wrap-around checksum of each 40-bit frame. Converts the frame to tenths of
// %RH and signed tenths of degC, and keeps per-channel last-good values, saturating error
// counters and stale flags.
module dht_multi_decoder #(
  parameter int unsigned NCH          = 4,
  parameter int unsigned CHW          = 2,
  parameter int unsigned ERRW         = 8,
  parameter int unsigned STALE_CYCLES = 100000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CHW-1:0]  in_ch,
  input  logic            in_mode,
  input  logic [39:0]     in_frame,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CHW-1:0]  out_ch,
  output logic            out_ok,
  output logic [15:0]     out_hum,
  output logic [15:0]     out_temp,
  output logic [ERRW-1:0] out_err_cnt,
  output logic [NCH-1:0]  stale
);

  localparam int unsigned     StaleW   = $clog2(STALE_CYCLES + 1);
  localparam logic [StaleW-1:0] StaleMax = StaleW'(STALE_CYCLES);
  localparam logic [ERRW-1:0] ErrMax   = '1;
  localparam logic [CHW:0]    NchLim   = (CHW + 1)'(NCH);

  typedef enum logic [1:0] {StIdle, StSum, StConv, StOut} state_t;

  state_t          state_q;
  logic [CHW-1:0]  ch_q;
  logic            mode_q;
  logic [39:0]     frame_q;
  logic            good_q;

  logic [15:0]       last_hum_q  [NCH];
  logic [15:0]       last_temp_q [NCH];
  logic [ERRW-1:0]   err_cnt_q   [NCH];
  logic [StaleW-1:0] stale_cnt_q [NCH];

  logic [7:0]      b0, b1, b2, b3, b4;
  logic [7:0]      sum;
  logic            ch_ok;
  logic [NCH-1:0]  ch_hit;
  logic [15:0]     sel_hum;
  logic [15:0]     sel_temp;
  logic [ERRW-1:0] sel_err;
  logic [ERRW-1:0] err_next;
  logic [7:0]      b1_clamp;
  logic [7:0]      b3_mag;
  logic [7:0]      b3_clamp;
  logic [15:0]     hum_conv;
  logic [15:0]     temp_mag;
  logic            temp_neg;
  logic [15:0]     temp_conv;
  logic [NCH-1:0]  stale_clr;

  // Split the captured frame and compute checksum and channel range.
  always_comb begin
    {b0, b1, b2, b3, b4} = frame_q;
    sum   = b0 + b1 + b2 + b3;
    ch_ok = {1'b0, ch_q} < NchLim;
  end

  // Decode the captured channel and mux out its stored state.
  always_comb begin
    ch_hit   = '0;
    sel_hum  = '0;
    sel_temp = '0;
    sel_err  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_q == CHW'(i)) begin
        ch_hit[i] = 1'b1;
        sel_hum   = last_hum_q[i];
        sel_temp  = last_temp_q[i];
        sel_err   = err_cnt_q[i];
      end
    end
    err_next = (sel_err == ErrMax) ? sel_err : sel_err + ERRW'(1);
  end

  // Convert DHT11 or DHT22 byte layout to tenths of %RH and signed tenths of degC.
  always_comb begin
    b1_clamp = (b1 > 8'd9) ? 8'd9 : b1;
    b3_mag   = {1'b0, b3[6:0]};
    b3_clamp = (b3_mag > 8'd9) ? 8'd9 : b3_mag;
    if (mode_q) begin
      hum_conv = {b0, b1};
      temp_mag = {1'b0, b2[6:0], b3};
      temp_neg = b2[7];
    end else begin
      hum_conv = ({8'h00, b0} * 16'd10) + {8'h00, b1_clamp};
      temp_mag = ({8'h00, b2} * 16'd10) + {8'h00, b3_clamp};
      temp_neg = b3[7];
    end
    temp_conv = temp_neg ? (16'd0 - temp_mag) : temp_mag;
  end

  // Frame FSM with registered handshake signals, result fields and per-channel state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ch_q        <= '0;
      mode_q      <= 1'b0;
      frame_q     <= '0;
      good_q      <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_ch      <= '0;
      out_ok      <= 1'b0;
      out_hum     <= '0;
      out_temp    <= '0;
      out_err_cnt <= '0;
      for (int i = 0; i < NCH; i++) begin
        last_hum_q[i]  <= '0;
        last_temp_q[i] <= '0;
        err_cnt_q[i]   <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            ch_q     <= in_ch;
            mode_q   <= in_mode;
            frame_q  <= in_frame;
            in_ready <= 1'b0;
            state_q  <= StSum;
          end
        end
        StSum: begin
          // An all-zero frame reads as a correct checksum but means the line is dead.
          good_q  <= (sum == b4) && (frame_q != 40'd0) && ch_ok;
          state_q <= StConv;
        end
        StConv: begin
          out_ch    <= ch_q;
          out_ok    <= good_q;
          out_valid <= 1'b1;
          state_q   <= StOut;
          if (good_q) begin
            out_hum     <= hum_conv;
            out_temp    <= temp_conv;
            out_err_cnt <= sel_err;
            for (int i = 0; i < NCH; i++) begin
              if (ch_hit[i]) begin
                last_hum_q[i]  <= hum_conv;
                last_temp_q[i] <= temp_conv;
              end
            end
          end else if (ch_ok) begin
            out_hum     <= sel_hum;
            out_temp    <= sel_temp;
            out_err_cnt <= err_next;
            for (int i = 0; i < NCH; i++) begin
              if (ch_hit[i]) begin
                err_cnt_q[i] <= err_next;
              end
            end
          end else begin
            // Out-of-range channel: report nothing and leave every channel untouched.
            out_hum     <= '0;
            out_temp    <= '0;
            out_err_cnt <= '0;
          end
        end
        StOut: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // A good frame clears its channel's stale timer on the same edge as the last-good update.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      stale_clr[i] = (state_q == StConv) && good_q && ch_hit[i];
    end
  end

  // Free-running saturating stale timers; a clear wins over the increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        stale_cnt_q[i] <= StaleMax;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (stale_clr[i]) begin
          stale_cnt_q[i] <= '0;
        end else if (stale_cnt_q[i] != StaleMax) begin
          stale_cnt_q[i] <= stale_cnt_q[i] + StaleW'(1);
        end
      end
    end
  end

  // Stale flag is set while the timer sits at its saturation value.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      stale[i] = (stale_cnt_q[i] == StaleMax);
    end
  end

endmodule

// File: tb/tb_dht_multi_decoder.sv
// Self-checking bench for dht_multi_decoder: per-scenario tasks plus a result scoreboard.
module tb_dht_multi_decoder;

  localparam int unsigned NCH   = 4;
  localparam int unsigned CHW   = 3;
  localparam int unsigned ERRW  = 8;
  localparam int unsigned STALE = 20;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [CHW-1:0]  in_ch;
  logic            in_mode;
  logic [39:0]     in_frame;
  logic            out_valid;
  logic            out_ready;
  logic [CHW-1:0]  out_ch;
  logic            out_ok;
  logic [15:0]     out_hum;
  logic [15:0]     out_temp;
  logic [ERRW-1:0] out_err_cnt;
  logic [NCH-1:0]  stale;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [CHW-1:0]  ch;
    logic            ok;
    logic [15:0]     hum;
    logic [15:0]     temp;
    logic [ERRW-1:0] err;
  } exp_t;

  exp_t            sb[$];
  exp_t            mon_e;
  logic [15:0]     m_hum  [NCH];
  logic [15:0]     m_temp [NCH];
  logic [ERRW-1:0] m_err  [NCH];

  dht_multi_decoder #(
    .NCH         (NCH),
    .CHW         (CHW),
    .ERRW        (ERRW),
    .STALE_CYCLES(STALE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ch      (in_ch),
    .in_mode    (in_mode),
    .in_frame   (in_frame),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ch     (out_ch),
    .out_ok     (out_ok),
    .out_hum    (out_hum),
    .out_temp   (out_temp),
    .out_err_cnt(out_err_cnt),
    .stale      (stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_hum[i]  = '0;
      m_temp[i] = '0;
      m_err[i]  = '0;
    end
    sb.delete();
  endtask

  // Reference model: derive the expected result of an accepted frame and queue it.
  task automatic push_expected(input logic [CHW-1:0] ch, input logic mode, input logic [39:0] fr);
    exp_t       e;
    logic [7:0] b0, b1, b2, b3, b4, s, lo;
    int         idx, hum, mag;
    bit         neg, good;
    b0 = fr[39:32]; b1 = fr[31:24]; b2 = fr[23:16]; b3 = fr[15:8]; b4 = fr[7:0];
    s    = b0 + b1 + b2 + b3;
    idx  = int'(ch);
    good = (s == b4) && (fr != 40'd0) && (idx < int'(NCH));
    if (mode) begin
      hum = int'({b0, b1});
      mag = int'({b2[6:0], b3});
      neg = b2[7];
    end else begin
      lo  = {1'b0, b3[6:0]};
      hum = int'(b0) * 10 + ((b1 > 8'd9) ? 9 : int'(b1));
      mag = int'(b2) * 10 + ((lo > 8'd9) ? 9 : int'(lo));
      neg = b3[7];
    end
    e.ch = ch;
    if (good) begin
      m_hum[idx]  = 16'(hum);
      m_temp[idx] = neg ? 16'(-mag) : 16'(mag);
      e.ok = 1'b1; e.hum = m_hum[idx]; e.temp = m_temp[idx]; e.err = m_err[idx];
    end else if (idx < int'(NCH)) begin
      if (m_err[idx] != '1) m_err[idx] = m_err[idx] + 1'b1;
      e.ok = 1'b0; e.hum = m_hum[idx]; e.temp = m_temp[idx]; e.err = m_err[idx];
    end else begin
      e.ok = 1'b0; e.hum = '0; e.temp = '0; e.err = '0;
    end
    sb.push_back(e);
  endtask

  // Scoreboard: every output handshake pops and compares the oldest expected result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got ch=%0d ok=%0b hum=%0d, want no result", out_ch, out_ok,
                 out_hum);
      end else begin
        mon_e = sb.pop_front();
        if ({out_ch, out_ok, out_hum, out_temp, out_err_cnt} !==
            {mon_e.ch, mon_e.ok, mon_e.hum, mon_e.temp, mon_e.err}) begin
          failures++;
          $display("FAIL sb_result got ch=%0d ok=%0b hum=%0d temp=%h err=%0d want ch=%0d ok=%0b hum=%0d temp=%h err=%0d",
                   out_ch, out_ok, out_hum, out_temp, out_err_cnt,
                   mon_e.ch, mon_e.ok, mon_e.hum, mon_e.temp, mon_e.err);
        end
      end
    end
  end

  // Offer a frame until accepted (bounded); called and returns at posedge + 1.
  task automatic send(input logic [CHW-1:0] ch, input logic mode, input logic [39:0] fr,
                      output int acc_cyc);
    logic rdy;
    bit   done;
    done     = 1'b0;
    acc_cyc  = -1;
    in_valid = 1'b1; in_ch = ch; in_mode = mode; in_frame = fr;
    for (int n = 0; n < 200 && !done; n++) begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        done    = 1'b1;
        acc_cyc = cyc;
      end
    end
    in_valid = 1'b0;
    if (done) begin
      push_expected(ch, mode, fr);
    end else begin
      checks++; failures++;
      $display("FAIL accept_timeout got in_ready=%0b, want accept within 200 cycles", in_ready);
    end
  endtask

  task automatic wait_out();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      if (out_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL out_timeout got out_valid=0, want 1 within 50 cycles");
    end
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    checks++;
    if ({in_ready, out_valid, out_ok} !== 3'b100) begin
      failures++;
      $display("FAIL reset_hs got rdy/vld/ok=%b, want 100", {in_ready, out_valid, out_ok});
    end
    checks++;
    if ({out_ch, out_hum, out_temp, out_err_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_fields got ch=%0d hum=%0d temp=%0d err=%0d, want 0", out_ch, out_hum,
               out_temp, out_err_cnt);
    end
    checks++;
    if (stale !== 4'hF) begin
      failures++;
      $display("FAIL reset_stale got %b, want 1111", stale);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, stale} !== {2'b10, 4'hF}) begin
      failures++;
      $display("FAIL reset_release got rdy=%0b vld=%0b stale=%b, want 1 0 1111", in_ready,
               out_valid, stale);
    end
  endtask

  task automatic test_dht11();
    int a;
    send(3'd0, 1'b0, 40'h37_00_19_05_55, a);
    wait_out();
    checks++;
    if ({out_ok, out_hum, out_temp} !== {1'b1, 16'd550, 16'd255}) begin
      failures++;
      $display("FAIL dht11_conv got ok=%0b hum=%0d temp=%0d, want 1 550 255", out_ok, out_hum,
               out_temp);
    end
    checks++;
    if (stale[0] !== 1'b0) begin
      failures++;
      $display("FAIL dht11_stale got stale0=%0b, want 0", stale[0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_dht22();
    int a;
    send(3'd1, 1'b1, 40'h02_8C_80_65_73, a);
    wait_out();
    checks++;
    if ({out_ok, out_hum, out_temp} !== {1'b1, 16'd652, 16'hFF9B}) begin
      failures++;
      $display("FAIL dht22_neg got ok=%0b hum=%0d temp=%h, want 1 652 ff9b", out_ok, out_hum,
               out_temp);
    end
    send(3'd1, 1'b1, 40'h02_8C_01_5F_EE, a);
    wait_out();
    checks++;
    if ({out_ok, out_temp} !== {1'b1, 16'd351}) begin
      failures++;
      $display("FAIL dht22_pos got ok=%0b temp=%0d, want 1 351", out_ok, out_temp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bad_checksum();
    int a;
    for (int i = 0; i < 300; i++) begin
      send(3'd1, 1'b1, 40'h02_8C_01_5F_EF, a);
      if (i == 0) begin
        wait_out();
        checks++;
        if ({out_ok, out_err_cnt} !== {1'b0, 8'd1}) begin
          failures++;
          $display("FAIL badsum_first got ok=%0b err=%0d, want 0 1", out_ok, out_err_cnt);
        end
      end
    end
    wait_out();
    checks++;
    if ({out_ok, out_hum, out_temp, out_err_cnt} !== {1'b0, 16'd652, 16'd351, 8'd255}) begin
      failures++;
      $display("FAIL badsum_sat got ok=%0b hum=%0d temp=%0d err=%0d, want 0 652 351 255", out_ok,
               out_hum, out_temp, out_err_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bad_frames();
    int a;
    send(3'd2, 1'b0, 40'h0, a);
    wait_out();
    checks++;
    if ({out_ok, out_hum, out_err_cnt} !== {1'b0, 16'd0, 8'd1}) begin
      failures++;
      $display("FAIL zero_frame got ok=%0b hum=%0d err=%0d, want 0 0 1", out_ok, out_hum,
               out_err_cnt);
    end
    send(3'd5, 1'b0, 40'h37_00_19_05_55, a);
    wait_out();
    checks++;
    if ({out_ch, out_ok, out_hum, out_temp, out_err_cnt} !== {3'd5, 1'b0, 40'd0}) begin
      failures++;
      $display("FAIL bad_ch got ch=%0d ok=%0b hum=%0d temp=%0d err=%0d, want 5 0 0 0 0", out_ch,
               out_ok, out_hum, out_temp, out_err_cnt);
    end
    // Good frames on every channel expose the error counts through the scoreboard.
    for (int c = 0; c < NCH; c++) begin
      send(CHW'(c), 1'b0, 40'h37_00_19_05_55, a);
    end
    wait_out();
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int acc[4];
    send(3'd0, 1'b1, 40'h01_F4_00_C8_BD, acc[0]);
    send(3'd2, 1'b0, 40'h2D_0F_0A_83_C9, acc[1]);
    send(3'd3, 1'b1, 40'h00_00_80_00_80, acc[2]);
    send(3'd1, 1'b0, 40'h0A_05_14_8C_AF, acc[3]);
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (acc[i] - acc[i-1] !== 4) begin
        failures++;
        $display("FAIL b2b_gap%0d got %0d cycles, want 4", i, acc[i] - acc[i-1]);
      end
    end
    wait_out();
    @(posedge clk); #1;
  endtask

  task automatic test_stale();
    int  a, n_fall, cnt;
    bit  hit, bad;
    hit = 1'b0;
    for (int n = 0; n < 100 && !hit; n++) begin
      if (stale[3]) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    send(3'd3, 1'b0, 40'h37_00_19_05_55, a);
    n_fall = -1;
    for (int n = 0; n < 10 && n_fall < 0; n++) begin
      @(posedge clk); #1;
      if (!stale[3]) n_fall = n;
    end
    checks++;
    if (n_fall != 1) begin
      failures++;
      $display("FAIL stale_clear_edge got %0d edges after accept, want 2", n_fall + 1);
    end
    cnt = 0; hit = 1'b0;
    for (int n = 0; n < 40 && !hit; n++) begin
      @(posedge clk); #1;
      cnt++;
      if (stale[3]) hit = 1'b1;
    end
    checks++;
    if (!hit || cnt != int'(STALE)) begin
      failures++;
      $display("FAIL stale_rise got %0d cycles (set=%0b), want %0d", cnt, hit, STALE);
    end
    // Good frame while saturated: flag holds one more edge, then drops on the clear edge.
    send(3'd3, 1'b0, 40'h37_00_19_05_55, a);
    @(posedge clk); #1;
    checks++;
    if (stale[3] !== 1'b1) begin
      failures++;
      $display("FAIL stale_hold got %0b, want 1", stale[3]);
    end
    @(posedge clk); #1;
    checks++;
    if (stale[3] !== 1'b0) begin
      failures++;
      $display("FAIL stale_sat_clear got %0b, want 0", stale[3]);
    end
    // Clear lands on the very edge the timer would reach saturation.
    repeat (17) @(posedge clk);
    #1;
    send(3'd3, 1'b0, 40'h37_00_19_05_55, a);
    bad = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      if (stale[3]) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL stale_race got stale3=1 near clear edge, want 0");
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    int a;
    bit bad;
    out_ready = 1'b0;
    send(3'd0, 1'b1, 40'h01_F4_00_C8_BD, a);
    wait_out();
    in_valid = 1'b1; in_ch = 3'd2; in_mode = 1'b0; in_frame = 40'h2D_0F_0A_83_C9;
    bad = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if ({in_ready, out_valid, out_ch, out_ok, out_hum, out_temp} !==
          {2'b01, 3'd0, 1'b1, 16'd500, 16'd200}) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL stall_hold got rdy=%0b vld=%0b hum=%0d temp=%0d, want 0 1 500 200",
               in_ready, out_valid, out_hum, out_temp);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL stall_release got rdy=%0b vld=%0b, want 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL stall_next_accept got rdy=%0b, want 0", in_ready);
    end else begin
      push_expected(3'd2, 1'b0, 40'h2D_0F_0A_83_C9);
    end
    in_valid = 1'b0;
    wait_out();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    bit bad;
    in_valid = 1'b1; in_ch = 3'd1; in_mode = 1'b0; in_frame = 40'h37_00_19_05_55;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, out_ok, out_hum, out_temp, out_err_cnt, stale} !==
        {3'b100, 40'd0, 4'hF}) begin
      failures++;
      $display("FAIL rst_mid got rdy=%0b vld=%0b ok=%0b hum=%0d stale=%b, want 1 0 0 0 1111",
               in_ready, out_valid, out_ok, out_hum, stale);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (out_valid) bad = 1'b1;
    end
    checks++;
    if (bad || stale !== 4'hF) begin
      failures++;
      $display("FAIL rst_discard got vld_seen=%0b stale=%b, want 0 1111", bad, stale);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_ch = '0; in_mode = 1'b0; in_frame = '0; out_ready = 1'b1;
    test_reset();
    test_dht11();
    test_dht22();
    test_bad_checksum();
    test_bad_frames();
    test_back_to_back();
    test_stale();
    test_stall();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got %0d pending results, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
